// File: rtl/led_counter_pkg.sv
// Shared types and default parameter values for the LED counter controller.
package led_counter_pkg;

  // Operating mode. Encoding 2'd3 is never produced; the FSM treats it as RUN.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    STEP  = 2'd2
  } mode_e;

  localparam int DEF_COUNTER_WIDTH   = 32;
  localparam int DEF_NUM_LEDS        = 10;
  localparam int DEF_LED_MSB         = 28;
  localparam int DEF_MOD_VALUE       = 0;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: a 2-flop synchroniser, a stability debouncer and a
// rising-edge detector. One press pulse is produced per debounced press.
module btn_debounce
  import led_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronise, then flip the debounced level only after DEBOUNCE_CYCLES
  // consecutive samples that disagree with it. The press pulse is raised in
  // the same edge that the level rises, so holding the button yields one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_counter_ctrl.sv
// Up/down counter with optional modulus, driven by a three-mode FSM
// (RUN / PAUSE / STEP) that advances on a debounced push-button press.
// The LED bus is a live slice of the counter.
module led_counter_ctrl
  import led_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH   = DEF_COUNTER_WIDTH,
  parameter int NUM_LEDS        = DEF_NUM_LEDS,
  parameter int LED_MSB         = DEF_LED_MSB,
  parameter int MOD_VALUE       = DEF_MOD_VALUE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     dir_sw,
  input  logic                     btn,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic [NUM_LEDS-1:0]      led,
  output logic                     wrap,
  output logic [1:0]               mode
);

  // Highest legal count: MOD_VALUE-1, or all ones for natural binary wrap.
  // Using the same limit for both cases keeps the up/down wrap logic uniform.
  localparam logic [COUNTER_WIDTH-1:0] MOD_MAX =
    (MOD_VALUE > 0) ? COUNTER_WIDTH'(MOD_VALUE - 1) : {COUNTER_WIDTH{1'b1}};

  // Handshake note: there is no valid/ready pair here. 'press' is a one-cycle
  // strobe consumed unconditionally by the mode FSM in the cycle it is high;
  // 'step_en' is a one-cycle strobe consumed by the counter in the same way.

  logic                     dir_sync1;
  logic                     dir_sync2;
  logic                     press;
  logic                     en_q;
  mode_e                    mode_q;
  mode_e                    mode_next;
  logic                     step_en;
  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] count_next;
  logic                     wrap_q;
  logic                     wrap_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn),
    .press (press)
  );

  // Direction switch synchroniser and enable history for STEP edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_sync1 <= 1'b0;
      dir_sync2 <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      dir_sync1 <= dir_sw;
      dir_sync2 <= dir_sync1;
      en_q      <= en;
    end
  end

  // Mode state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= RUN;
    end else begin
      mode_q <= mode_next;
    end
  end

  // Mode transitions and per-mode step qualification. The step decision uses
  // the current mode, so a press in the same cycle only affects later cycles.
  always_comb begin
    mode_next = mode_q;
    step_en   = 1'b0;
    case (mode_q)
      RUN: begin
        step_en = en;
        if (press) mode_next = PAUSE;
      end
      PAUSE: begin
        if (press) mode_next = STEP;
      end
      STEP: begin
        step_en = en & ~en_q;
        if (press) mode_next = RUN;
      end
      default: begin
        mode_next = RUN;
      end
    endcase
  end

  // Next count and wrap flag; wrap marks the cycle the wrapped value appears.
  always_comb begin
    count_next = count_q;
    wrap_next  = 1'b0;
    if (step_en) begin
      if (!dir_sync2) begin
        if (count_q == MOD_MAX) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_q + COUNTER_WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_next = MOD_MAX;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_q - COUNTER_WIDTH'(1);
        end
      end
    end
  end

  // Counter and wrap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_next;
      wrap_q  <= wrap_next;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign mode  = mode_q;
  assign led   = count_q[LED_MSB -: NUM_LEDS];

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Directed testbench for led_counter_ctrl with an 8-bit counter, modulus 10,
// 4 LEDs and a 4-cycle debounce. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_led_counter_ctrl;

  localparam logic [1:0] M_RUN   = 2'd0;
  localparam logic [1:0] M_PAUSE = 2'd1;
  localparam logic [1:0] M_STEP  = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir_sw = 1'b0;
  logic       btn = 1'b0;
  logic [7:0] count;
  logic [3:0] led;
  logic       wrap;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  led_counter_ctrl #(
    .COUNTER_WIDTH   (8),
    .NUM_LEDS        (4),
    .LED_MSB         (3),
    .MOD_VALUE       (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .dir_sw (dir_sw),
    .btn    (btn),
    .count  (count),
    .led    (led),
    .wrap   (wrap),
    .mode   (mode)
  );

  // Clock
  always #5 clk = ~clk;

  // Reset values after synchronous-looking reset hold.
  task automatic test_reset;
    rst = 1'b1; en = 1'b0; dir_sw = 1'b0; btn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
    checks++; if (mode !== M_RUN) begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
    checks++; if (led !== 4'd0) begin errors++; $display("FAIL reset_led got %0d want 0", led); end
    rst = 1'b0;
  endtask

  // RUN counting up through the modulus: 0..9,0,1 with wrap on the 9->0 cycle.
  task automatic test_run_up;
    logic [7:0] exp;
    logic       exp_wrap;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp = 8'(i % 10);
      exp_wrap = (i == 10);
      checks++; if (count !== exp) begin errors++; $display("FAIL run_up_count cycle %0d got %0d want %0d", i, count, exp); end
      checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL run_up_wrap cycle %0d got %b want %b", i, wrap, exp_wrap); end
      checks++; if (led !== exp[3:0]) begin errors++; $display("FAIL run_up_led cycle %0d got %0d want %0d", i, led, exp[3:0]); end
      if (i == 0) en = 1'b1;
      if (i == 11) en = 1'b0;
    end
  endtask

  // RUN counting down from 0: 9 (wrap), 8, 7, then hold with en low.
  task automatic test_run_down;
    logic [7:0] exp_cnt [3];
    logic       exp_wr  [3];
    exp_cnt = '{8'd9, 8'd8, 8'd7};
    exp_wr  = '{1'b1, 1'b0, 1'b0};
    dir_sw = 1'b1; en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL run_down_start got %0d want 0", count); end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (count !== exp_cnt[i]) begin errors++; $display("FAIL run_down_count step %0d got %0d want %0d", i, count, exp_cnt[i]); end
      checks++; if (wrap !== exp_wr[i]) begin errors++; $display("FAIL run_down_wrap step %0d got %b want %b", i, wrap, exp_wr[i]); end
    end
    en = 1'b0;
    @(negedge clk);
    checks++; if (count !== 8'd7) begin errors++; $display("FAIL run_down_hold got %0d want 7", count); end
  endtask

  // Reset asserted between edges clears state without a clock edge.
  task automatic test_async_reset;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL async_rst_count got %0d want 0", count); end
    checks++; if (mode !== M_RUN) begin errors++; $display("FAIL async_rst_mode got %0d want 0", mode); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL async_rst_wrap got %b want 0", wrap); end
    dir_sw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    checks++; if (count !== 8'd5) begin errors++; $display("FAIL async_rst_recount got %0d want 5", count); end
    checks++; if (led !== 4'd5) begin errors++; $display("FAIL async_rst_led got %0d want 5", led); end
  endtask

  // Short button glitches are ignored; a long press moves RUN -> PAUSE once.
  task automatic test_glitch;
    int         transitions;
    logic [1:0] prev;
    en = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      btn = 1'b1;
      repeat (w) @(negedge clk);
      btn = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        checks++; if (mode !== M_RUN) begin errors++; $display("FAIL glitch_mode width %0d got %0d want 0", w, mode); end
      end
    end
    transitions = 0;
    prev = mode;
    btn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mode !== prev) transitions++;
      prev = mode;
      if (c == 9) btn = 1'b0;
    end
    checks++; if (transitions !== 1) begin errors++; $display("FAIL press_transitions got %0d want 1", transitions); end
    checks++; if (mode !== M_PAUSE) begin errors++; $display("FAIL press_mode got %0d want 1", mode); end
    checks++; if (count !== 8'd5) begin errors++; $display("FAIL press_count got %0d want 5", count); end
  endtask

  // PAUSE ignores en; press enters STEP; three en rising edges give +3.
  task automatic test_pause_step;
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (count !== 8'd5) begin errors++; $display("FAIL pause_hold cycle %0d got %0d want 5", c, count); end
    end
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (mode !== M_STEP) begin errors++; $display("FAIL step_mode got %0d want 2", mode); end
    checks++; if (count !== 8'd5) begin errors++; $display("FAIL step_entry_count got %0d want 5", count); end
    for (int t = 1; t <= 3; t++) begin
      en = 1'b0;
      repeat (2) @(negedge clk);
      en = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (count !== 8'(5 + t)) begin errors++; $display("FAIL step_count toggle %0d got %0d want %0d", t, count, 5 + t); end
    end
    en = 1'b0;
    @(negedge clk);
    checks++; if (count !== 8'd8) begin errors++; $display("FAIL step_final got %0d want 8", count); end
  endtask

  // Back to RUN, then a press landing on a RUN step: the step is taken and
  // counting stops from the next cycle on.
  task automatic test_press_with_step;
    logic [7:0] exp;
    logic       exp_wrap;
    logic [1:0] prev_mode;
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (mode !== M_RUN) begin errors++; $display("FAIL step_to_run_mode got %0d want 0", mode); end
    checks++; if (count !== 8'd8) begin errors++; $display("FAIL step_to_run_count got %0d want 8", count); end
    exp = 8'd8;
    prev_mode = M_RUN;
    en = 1'b1;
    btn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_wrap = 1'b0;
      if (prev_mode == M_RUN) begin
        exp_wrap = (exp == 8'd9);
        exp = (exp == 8'd9) ? 8'd0 : exp + 8'd1;
      end
      checks++; if (count !== exp) begin errors++; $display("FAIL press_step_count cycle %0d got %0d want %0d", c, count, exp); end
      checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL press_step_wrap cycle %0d got %b want %b", c, wrap, exp_wrap); end
      prev_mode = mode;
      if (c == 9) btn = 1'b0;
    end
    checks++; if (mode !== M_PAUSE) begin errors++; $display("FAIL press_step_mode got %0d want 1", mode); end
    checks++; if (exp == 8'd8) begin errors++; $display("FAIL press_step_progress got %0d want not 8", exp); end
    en = 1'b0;
  endtask

  // Reset mid-debounce discards the pending press; a button still held
  // across reset release then registers exactly one press.
  task automatic test_reset_btn_held;
    int         transitions;
    logic [1:0] prev;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (mode !== M_RUN) begin errors++; $display("FAIL held_rst_mode got %0d want 0", mode); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL held_rst_count got %0d want 0", count); end
    @(negedge clk);
    rst = 1'b0;
    transitions = 0;
    prev = mode;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (mode !== prev) transitions++;
      prev = mode;
      if (c == 11) btn = 1'b0;
    end
    checks++; if (transitions !== 1) begin errors++; $display("FAIL held_press_transitions got %0d want 1", transitions); end
    checks++; if (mode !== M_PAUSE) begin errors++; $display("FAIL held_press_mode got %0d want 1", mode); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL held_press_count got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_run_up();
    test_run_down();
    test_async_reset();
    test_glitch();
    test_pause_step();
    test_press_with_step();
    test_reset_btn_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time bound so the bench always ends on its own.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_counter_ctrl.md
LED_COUNTER_CTRL -- requirements
Module: led_counter_ctrl

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32: counter width in bits.
REQ-002 SHALL have parameter NUM_LEDS, default 10: number of LED outputs.
REQ-003 SHALL have parameter LED_MSB, default 28: counter bit driving led[NUM_LEDS-1]; LED_MSB < COUNTER_WIDTH and LED_MSB+1 >= NUM_LEDS.
REQ-004 SHALL have parameter MOD_VALUE, default 0: 0 = natural 2^COUNTER_WIDTH wrap; otherwise count range is 0..MOD_VALUE-1.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 16: required stable cycles for btn.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  count enable, synchronous to clk.
REQ-009 dir_sw  input  1  raw asynchronous direction switch; 0 = up, 1 = down.
REQ-010 btn  input  1  raw asynchronous, bouncing push-button; high = pressed.
REQ-011 count  output  COUNTER_WIDTH  current counter value.
REQ-012 led  output  NUM_LEDS  count[LED_MSB : LED_MSB-NUM_LEDS+1].
REQ-013 wrap  output  1  single-cycle wrap indication.
REQ-014 mode  output  2  current mode encoding: RUN=0, PAUSE=1, STEP=2.

Function
REQ-015 dir_sw and btn SHALL each pass through a 2-flop synchroniser before use.
REQ-016 Synchronised btn SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal samples; shorter pulses SHALL have no effect.
REQ-017 A rising edge of the debounced btn SHALL produce a 1-cycle press pulse; holding btn SHALL produce no further pulses.
REQ-018 Mode FSM SHALL advance on press: RUN -> PAUSE -> STEP -> RUN; encoding 3 unreachable, and if entered SHALL return to RUN next cycle.
REQ-019 RUN: counter SHALL step once per clk cycle with en=1.
REQ-020 PAUSE: counter SHALL hold regardless of en.
REQ-021 STEP: counter SHALL step exactly once per en rising edge (en 0 in previous cycle, 1 in current).
REQ-022 Step SHALL be +1 when synchronised dir_sw=0, -1 when 1; a dir_sw change SHALL take effect within 3 cycles.
REQ-023 MOD_VALUE=0: arithmetic SHALL wrap modulo 2^COUNTER_WIDTH.
REQ-024 MOD_VALUE>0: up from MOD_VALUE-1 SHALL go to 0; down from 0 SHALL go to MOD_VALUE-1.
REQ-025 wrap SHALL be high for exactly the one cycle in which count shows the wrapped value (registered with count).
REQ-026 A press coinciding with a step SHALL let the step follow the old mode; new mode applies from the next cycle.
REQ-027 led SHALL be purely combinational from count, zero added latency.

Reset
REQ-028 rst high SHALL asynchronously force count=0, wrap=0, mode=RUN, synchroniser flops=0, debounce counter=0, debounced btn=0, en history=0.
REQ-029 Reset mid-debounce or mid-step SHALL discard pending press/step; first step after release SHALL follow REQ-019..REQ-024 from count=0.
REQ-030 btn held high across rst release SHALL register one press once debounced.

Structure
REQ-031 Package led_counter_pkg SHALL hold the mode enum (RUN, PAUSE, STEP) and default parameter constants.
REQ-032 Synchroniser plus debouncer plus edge detector SHALL be one sub-module, btn_debounce, parameterised by DEBOUNCE_CYCLES, instantiated once for btn.
REQ-033 Top level SHALL contain mode FSM, counter/wrap logic and led slice; no io_oeb handling (done by integrating top).

Verification (COUNTER_WIDTH=8, NUM_LEDS=4, LED_MSB=3, MOD_VALUE=10, DEBOUNCE_CYCLES=4)
REQ-034 RUN, dir_sw=0, en=1 for 12 cycles after reset -> count 0..9,0,1; wrap high only in cycle count=0 after 9; led=count[3:0].
REQ-035 RUN, dir_sw=1 from count=0, en=1 -> count 9,8,7; wrap high in cycle count=9.
REQ-036 btn glitches of 1-3 cycles -> mode stays RUN; btn high 10 cycles -> mode=PAUSE, exactly one transition.
REQ-037 PAUSE with en=1 for 20 cycles -> count unchanged; press -> STEP; en toggled 3 times (0->1) -> count +3.
REQ-038 rst asserted between clock edges at count=7 -> count=0, mode=RUN immediately, without waiting for clk.
REQ-039 Press edge in same cycle as RUN step -> that step taken, count frozen from following cycle (PAUSE).
